// File: rtl/dvi_timing_ctrl_if.sv
// Video timing bus between the DVI timing sequencer and its consumers:
// the pixel source (request side) and the three TMDS encoders (de/syncs).
`timescale 1ns/1ps

interface dvi_timing_ctrl_if;
   logic        en;
   logic        req;
   logic [11:0] req_x;
   logic [11:0] req_y;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic        frame_start;
   logic        running;

   // Sequencer side: takes the run request, drives timing and requests.
   modport master (
      input  en,
      output req, req_x, req_y, de, hsync, vsync, frame_start, running
   );

   // Consumer side: raises the run request, observes timing and requests.
   modport slave (
      output en,
      input  req, req_x, req_y, de, hsync, vsync, frame_start, running
   );
endinterface

// File: rtl/dvi_timing_ctrl.sv
// DVI raster timing sequencer. Walks a programmable raster and produces a
// pixel request one cycle ahead of de, plus hsync/vsync aligned with de.
// Starting and stopping only happen on frame boundaries.
`timescale 1ns/1ps

module dvi_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic              clkin,
   input  logic              rstin,
   dvi_timing_ctrl_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
   localparam logic [11:0] H_SYN_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SYN_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] V_SYN_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SYN_END = 12'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   state_t      state_next;
   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic        frame_last;
   logic        pix_act;
   logic        hs_act;
   logic        vs_act;
   logic        hs_req;   // sync flags aligned with req, delayed once more to align with de
   logic        vs_req;

   assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

   // State register.
   always_ff @(posedge clkin or posedge rstin) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block ordering.
      if (rstin) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state: start on en, stop only at the last cycle of a frame.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_next unassigned
      // (which would infer a latch).
      state_next = state;
      case (state)
         IDLE:    if (bus.en) state_next = RUN;
         RUN:     if (frame_last && !bus.en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Raster position counters; held at the origin while idle.
   always_ff @(posedge clkin or posedge rstin) begin
      if (rstin) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (state == IDLE) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   // Region decode of the current position (only meaningful while running).
   always_comb begin
      pix_act = (state == RUN) && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      hs_act  = (state == RUN) && (h_cnt >= H_SYN_BEG) && (h_cnt < H_SYN_END);
      vs_act  = (state == RUN) && (v_cnt >= V_SYN_BEG) && (v_cnt < V_SYN_END);
   end

   // Request stage: pixel request, coordinates and frame start, one cycle ahead of de.
   always_ff @(posedge clkin or posedge rstin) begin
      if (rstin) begin
         bus.req         <= 1'b0;
         bus.req_x       <= '0;
         bus.req_y       <= '0;
         bus.frame_start <= 1'b0;
         bus.running     <= 1'b0;
         hs_req          <= 1'b0;
         vs_req          <= 1'b0;
      end else begin
         bus.req         <= pix_act;
         bus.frame_start <= pix_act && (h_cnt == 12'd0) && (v_cnt == 12'd0);
         bus.running     <= (state_next == RUN);
         hs_req          <= hs_act;
         vs_req          <= vs_act;
         if (pix_act) begin
            bus.req_x <= h_cnt;
            bus.req_y <= v_cnt;
         end
      end
   end

   // Encoder stage: de and polarity-adjusted syncs, aligned with returned pixel data.
   always_ff @(posedge clkin or posedge rstin) begin
      if (rstin) begin
         bus.de    <= 1'b0;
         bus.hsync <= ~HS_POL;
         bus.vsync <= ~VS_POL;
      end else begin
         bus.de    <= bus.req;
         bus.hsync <= hs_req ~^ HS_POL;
         bus.vsync <= vs_req ~^ VS_POL;
      end
   end

endmodule
